// File: rtl/uart_cmd_controller.sv
// Frame-level command controller between uart_top FIFOs and the gripper register file.
// Parses SOF/CMD/ADDR/DH/DL/CHK frames, executes register access, queues a 5-byte response.
module uart_cmd_controller #(
  parameter int          DATA_BITS = 8,
  parameter logic [7:0]  CMD_SOF   = 8'hA5,
  parameter logic [7:0]  RSP_SOF   = 8'h5A,
  parameter int          NUM_REGS  = 4,
  parameter int          TIMEOUT   = 50000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 rx_empty,
  input  logic [DATA_BITS-1:0] read_data,
  output logic                 read_uart,
  input  logic                 tx_full,
  output logic                 write_uart,
  output logic [DATA_BITS-1:0] write_data,
  output logic                 reg_wr_en,
  output logic [7:0]           reg_addr,
  output logic [15:0]          reg_wr_data,
  input  logic [15:0]          reg_rd_data,
  output logic                 frame_err,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_CMD  = 3'd1,
    GET_ADDR = 3'd2,
    GET_DH   = 3'd3,
    GET_DL   = 3'd4,
    GET_CHK  = 3'd5,
    EXEC     = 3'd6,
    SEND     = 3'd7
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cmd_reg, addr_reg, dh_reg, dl_reg, chk_reg;
  logic [7:0]  status_reg, rsp_dh_reg, rsp_dl_reg;
  logic [2:0]  idx_reg;
  logic [15:0] timer_reg;

  logic        is_get, pop, push, timed_out;
  logic [7:0]  exec_status;
  logic [15:0] exec_data;
  logic        exec_fail;
  logic [7:0]  rsp_byte;

  assign is_get    = state_reg inside {GET_CMD, GET_ADDR, GET_DH, GET_DL, GET_CHK};
  assign pop       = ((state_reg == IDLE) || is_get) && !rx_empty && !RESET;
  assign push      = (state_reg == SEND) && !tx_full && !RESET;
  assign timed_out = is_get && rx_empty && (timer_reg == 16'(TIMEOUT - 1));

  // Checks in priority order: checksum, command, address; first failure wins.
  always_comb begin
    exec_status = 8'h00;
    exec_data   = 16'h0000;
    exec_fail   = 1'b0;
    if ((cmd_reg ^ addr_reg ^ dh_reg ^ dl_reg) != chk_reg) begin
      exec_status = 8'hE1;
      exec_fail   = 1'b1;
    end else if ((cmd_reg != 8'h01) && (cmd_reg != 8'h02)) begin
      exec_status = 8'hE2;
      exec_fail   = 1'b1;
    end else if (32'(addr_reg) >= NUM_REGS) begin
      exec_status = 8'hE3;
      exec_fail   = 1'b1;
    end else if (cmd_reg == 8'h01) begin
      exec_status = 8'h00;
      exec_data   = {dh_reg, dl_reg};
    end else begin
      exec_status = 8'h01;
      exec_data   = reg_rd_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (pop && (read_data == CMD_SOF)) state_next = GET_CMD;
      GET_CMD, GET_ADDR, GET_DH, GET_DL, GET_CHK: begin
        // GET_* states are consecutive codes, GET_CHK + 1 is EXEC
        if (pop)            state_next = state_t'(state_reg + 3'd1);
        else if (timed_out) state_next = IDLE;
      end
      EXEC:     state_next = SEND;
      SEND:     if (push && (idx_reg == 3'd4)) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd_reg    <= 8'h00;
      addr_reg   <= 8'h00;
      dh_reg     <= 8'h00;
      dl_reg     <= 8'h00;
      chk_reg    <= 8'h00;
      status_reg <= 8'h00;
      rsp_dh_reg <= 8'h00;
      rsp_dl_reg <= 8'h00;
      idx_reg    <= 3'd0;
      timer_reg  <= 16'h0000;
    end else begin
      if (is_get && rx_empty && !timed_out) timer_reg <= timer_reg + 16'h0001;
      else                                  timer_reg <= 16'h0000;
      if (pop) begin
        case (state_reg)
          GET_CMD:  cmd_reg  <= read_data;
          GET_ADDR: addr_reg <= read_data;
          GET_DH:   dh_reg   <= read_data;
          GET_DL:   dl_reg   <= read_data;
          GET_CHK:  chk_reg  <= read_data;
          default:  ;
        endcase
      end
      if (state_reg == EXEC) begin
        status_reg <= exec_status;
        rsp_dh_reg <= exec_data[15:8];
        rsp_dl_reg <= exec_data[7:0];
        idx_reg    <= 3'd0;
      end else if (push) begin
        idx_reg <= (idx_reg == 3'd4) ? 3'd0 : idx_reg + 3'd1;
      end
    end
  end

  always_comb begin
    case (idx_reg)
      3'd0:    rsp_byte = RSP_SOF;
      3'd1:    rsp_byte = status_reg;
      3'd2:    rsp_byte = rsp_dh_reg;
      3'd3:    rsp_byte = rsp_dl_reg;
      default: rsp_byte = status_reg ^ rsp_dh_reg ^ rsp_dl_reg;
    endcase
  end

  // Every output is forced low while RESET is high, strobes included.
  always_comb begin
    read_uart   = 1'b0;
    write_uart  = 1'b0;
    write_data  = '0;
    reg_wr_en   = 1'b0;
    reg_addr    = 8'h00;
    reg_wr_data = 16'h0000;
    frame_err   = 1'b0;
    busy        = 1'b0;
    if (!RESET) begin
      read_uart   = pop;
      write_uart  = push;
      write_data  = rsp_byte;
      reg_addr    = addr_reg;
      reg_wr_data = {dh_reg, dl_reg};
      busy        = (state_reg != IDLE);
      if (state_reg == EXEC) begin
        reg_wr_en = !exec_fail && (cmd_reg == 8'h01);
        frame_err = exec_fail;
      end
      if (timed_out) frame_err = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Self-checking bench for uart_cmd_controller: FIFO/register-file environment plus a
// frame-level reference model of the expected responses, register writes and errors.
module tb_uart_cmd_controller;

  localparam int TO    = 64;
  localparam int NREGS = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        rx_empty = 1'b1;
  logic [7:0]  read_data = 8'h00;
  logic        read_uart;
  logic        tx_full = 1'b0;
  logic        write_uart;
  logic [7:0]  write_data;
  logic        reg_wr_en;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wr_data;
  logic [15:0] reg_rd_data;
  logic        frame_err;
  logic        busy;

  uart_cmd_controller #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .rx_empty(rx_empty), .read_data(read_data),
    .read_uart(read_uart), .tx_full(tx_full), .write_uart(write_uart),
    .write_data(write_data), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  logic [15:0] env_regs [NREGS];
  logic [15:0] model_regs [NREGS];
  assign reg_rd_data = (reg_addr < 8'(NREGS)) ? env_regs[reg_addr[1:0]] : 16'hDEAD;

  logic [7:0] rx_q [$];
  logic [7:0] tx_q [$];
  logic [7:0] exp_q [$];
  int cmp_cnt = 0, mis_cnt = 0;
  int cyc = 0, last_pop_cyc = 0, evt_gap = 0;
  int wr_cnt = 0, ferr_cnt = 0, pop_cnt = 0, exp_wr = 0, exp_err = 0;
  logic [23:0] last_wr_word = '0, exp_wr_word = '0;
  bit bp_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive FIFO inputs, sample outputs mid-cycle, then step to the next cycle.
  task automatic tick();
    if (bp_en) tx_full = ($urandom_range(0, 3) == 0);
    rx_empty  = (rx_q.size() == 0);
    read_data = rx_empty ? 8'h00 : rx_q[0];
    #1;
    if (write_uart) tx_q.push_back(write_data);
    if (reg_wr_en) begin
      wr_cnt++;
      last_wr_word = {reg_addr, reg_wr_data};
      evt_gap = cyc - last_pop_cyc;
      if (reg_addr < 8'(NREGS)) env_regs[reg_addr[1:0]] = reg_wr_data;
    end
    if (frame_err) begin
      ferr_cnt++;
      evt_gap = cyc - last_pop_cyc;
    end
    if (read_uart) begin
      pop_cnt++;
      last_pop_cyc = cyc;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end
    cyc++;
    @(negedge CLK);
    #1;
  endtask

  // Reference model: a command frame in, the expected response and side effects out.
  task automatic queue_frame(input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [7:0] dh, input logic [7:0] dl, input logic [7:0] chk);
    logic [7:0]  st;
    logic [15:0] d;
    rx_q.push_back(8'hA5);
    rx_q.push_back(cmd);
    rx_q.push_back(addr);
    rx_q.push_back(dh);
    rx_q.push_back(dl);
    rx_q.push_back(chk);
    d = 16'h0000;
    if ((cmd ^ addr ^ dh ^ dl) != chk)          st = 8'hE1;
    else if ((cmd != 8'h01) && (cmd != 8'h02))  st = 8'hE2;
    else if (int'(addr) >= NREGS)               st = 8'hE3;
    else if (cmd == 8'h01) begin
      st = 8'h00;
      d  = {dh, dl};
      model_regs[addr[1:0]] = d;
      exp_wr++;
      exp_wr_word = {addr, d};
    end else begin
      st = 8'h01;
      d  = model_regs[addr[1:0]];
    end
    if (st >= 8'hE0) exp_err++;
    exp_q.push_back(8'h5A);
    exp_q.push_back(st);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(st ^ d[15:8] ^ d[7:0]);
  endtask

  function automatic logic [7:0] chk_of(input logic [7:0] c, input logic [7:0] a,
                                        input logic [7:0] h, input logic [7:0] l);
    return c ^ a ^ h ^ l;
  endfunction

  task automatic drain(input string tag, input int exp_ticks);
    int n = 0;
    while ((tx_q.size() < exp_q.size()) && (n < 500)) begin
      tick();
      n++;
    end
    if (exp_ticks > 0) check($sformatf("%s latency", tag), n, exp_ticks);
    check($sformatf("%s tx_count", tag), tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s byte%0d", tag, i), (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hFFFF_FFFF, exp_q[i]);
    tick();
    check($sformatf("%s busy_after", tag), busy, 1'b0);
    check($sformatf("%s wr_count", tag), wr_cnt, exp_wr);
    check($sformatf("%s err_count", tag), ferr_cnt, exp_err);
    if (exp_wr > 0) check($sformatf("%s wr_word", tag), last_wr_word, exp_wr_word);
    tx_q.delete();
    exp_q.delete();
    wr_cnt = 0; ferr_cnt = 0; exp_wr = 0; exp_err = 0;
  endtask

  initial begin
    int n, p0;
    logic [7:0] c, a, h, l, k;
    for (int i = 0; i < NREGS; i++) begin
      env_regs[i]   = 16'($urandom);
      model_regs[i] = env_regs[i];
    end
    env_regs[1] = 16'hBEEF;
    model_regs[1] = 16'hBEEF;

    // Reset state
    repeat (3) tick();
    check("rst busy", busy, 1'b0);
    check("rst read_uart", read_uart, 1'b0);
    check("rst write_uart", write_uart, 1'b0);
    check("rst reg_wr_en", reg_wr_en, 1'b0);
    check("rst frame_err", frame_err, 1'b0);
    check("rst reg_addr", reg_addr, 8'h00);
    check("rst reg_wr_data", reg_wr_data, 16'h0000);
    check("rst write_data", write_data, 8'h00);
    RESET = 1'b0;
    tick();

    // Directed frames
    queue_frame(8'h01, 8'h02, 8'h12, 8'h34, chk_of(8'h01, 8'h02, 8'h12, 8'h34));
    drain("write", 12);
    check("write exec_gap", evt_gap, 1);
    check("write reg2", env_regs[2], 16'h1234);
    queue_frame(8'h02, 8'h01, 8'h00, 8'h00, 8'h03);
    drain("read", 12);
    queue_frame(8'h01, 8'h00, 8'h00, 8'h01, 8'h01);
    drain("badchk", 12);
    check("badchk exec_gap", evt_gap, 1);
    queue_frame(8'h07, 8'h00, 8'h00, 8'h00, 8'h07);
    queue_frame(8'h01, 8'h09, 8'h00, 8'h00, 8'h08);
    drain("badcmd_addr", 24);
    queue_frame(8'h07, 8'h09, 8'h00, 8'h00, 8'h00);
    queue_frame(8'h07, 8'h09, 8'h00, 8'h00, 8'h0E);
    drain("priority", 24);
    queue_frame(8'h01, 8'h03, 8'hA5, 8'hA5, chk_of(8'h01, 8'h03, 8'hA5, 8'hA5));
    drain("sof_data", 12);

    // Noise then a truncated frame left to time out
    p0 = pop_cnt;
    rx_q.push_back(8'h00); rx_q.push_back(8'hFF); rx_q.push_back(8'hA5); rx_q.push_back(8'h01);
    repeat (TO + 20) tick();
    check("timeout pops", pop_cnt - p0, 4);
    check("timeout err_count", ferr_cnt, 1);
    check("timeout gap", evt_gap, TO);
    check("timeout tx_count", tx_q.size(), 0);
    check("timeout busy", busy, 1'b0);
    check("timeout wr_count", wr_cnt, 0);
    ferr_cnt = 0; wr_cnt = 0;
    queue_frame(8'h02, 8'h02, 8'h00, 8'h00, chk_of(8'h02, 8'h02, 8'h00, 8'h00));
    drain("after_timeout", 12);

    // Backpressure in SEND
    queue_frame(8'h01, 8'h00, 8'hC3, 8'h3C, chk_of(8'h01, 8'h00, 8'hC3, 8'h3C));
    n = 0;
    while ((tx_q.size() < 2) && (n < 100)) begin tick(); n++; end
    tx_full = 1'b1;
    repeat (10) tick();
    check("bp held tx_count", tx_q.size(), 2);
    check("bp write_uart", write_uart, 1'b0);
    check("bp busy", busy, 1'b1);
    tx_full = 1'b0;
    drain("bp", 0);

    // Reset in the middle of SEND
    queue_frame(8'h02, 8'h01, 8'h00, 8'h00, 8'h03);
    n = 0;
    while ((tx_q.size() < 2) && (n < 100)) begin tick(); n++; end
    RESET = 1'b1;
    rx_q.push_back(8'h11); rx_q.push_back(8'h22);
    tick();
    tick();
    check("midrst busy", busy, 1'b0);
    check("midrst read_uart", read_uart, 1'b0);
    check("midrst write_uart", write_uart, 1'b0);
    check("midrst reg_addr", reg_addr, 8'h00);
    check("midrst write_data", write_data, 8'h00);
    check("midrst reg_wr_data", reg_wr_data, 16'h0000);
    RESET = 1'b0;
    p0 = pop_cnt;
    repeat (4) tick();
    check("postrst pops", pop_cnt - p0, 2);
    check("postrst tx_count", tx_q.size(), 2);
    check("postrst err_count", ferr_cnt, 0);
    check("postrst busy", busy, 1'b0);
    tx_q.delete(); exp_q.delete();
    wr_cnt = 0; ferr_cnt = 0; exp_wr = 0; exp_err = 0;
    queue_frame(8'h01, 8'h01, 8'h5A, 8'h01, chk_of(8'h01, 8'h01, 8'h5A, 8'h01));
    drain("postrst frame", 12);

    // Randomized frames with random TX backpressure
    bp_en = 1'b1;
    for (int it = 0; it < 30; it++) begin
      for (int f = 0; f < int'($urandom_range(1, 2)); f++) begin
        n = int'($urandom_range(0, 9));
        c = (n < 4) ? 8'h01 : (n < 8) ? 8'h02 : 8'($urandom);
        a = 8'($urandom_range(0, 5));
        h = 8'($urandom);
        l = 8'($urandom);
        k = chk_of(c, a, h, l);
        if ($urandom_range(0, 4) == 0) k = k ^ 8'($urandom_range(1, 255));
        queue_frame(c, a, h, l, k);
      end
      drain($sformatf("rand%0d", it), 0);
    end
    bp_en = 1'b0;
    tx_full = 1'b0;
    for (int i = 0; i < NREGS; i++)
      check($sformatf("final reg%0d", i), env_regs[i], model_regs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
